// File: rtl/fp_accumulator_bfloat16_if.sv
// Element/sum bus of the bfloat16 accumulator.
// The producer drives elements in; the accumulator drives sums out.
interface fp_accumulator_bfloat16_if #(
  parameter int COUNT_WIDTH = 16
) ();
  logic                   value_valid;
  logic                   value_ready;
  logic                   value_last;
  logic [24:0]            fp_value;
  logic                   acc_clear;
  logic                   sum_rdy;
  logic [24:0]            sum;
  logic [COUNT_WIDTH-1:0] sum_count;

  modport master (
    output value_valid, value_last, fp_value, acc_clear,
    input  value_ready, sum_rdy, sum, sum_count
  );

  modport slave (
    input  value_valid, value_last, fp_value, acc_clear,
    output value_ready, sum_rdy, sum, sum_count
  );
endinterface

// File: rtl/fp_accumulator_bfloat16.sv
// Multi-cycle bfloat16 product accumulator.
// Elements are {sign, exp[7:0] bias 127, frac[15:0] with hidden 1}; one
// element is absorbed per IDLE visit through ALIGN/ADD/NORM/ROUND and the
// rounded sum is emitted when the element flagged last completes.
module fp_accumulator_bfloat16 #(
  parameter int COUNT_WIDTH = 16
) (
  input logic                      clk,
  input logic                      rstn,
  fp_accumulator_bfloat16_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;
  state_t state, state_nxt;

  logic                   ready, xfer;
  logic [24:0]            acc;        // running sum, element format
  logic [COUNT_WIDTH-1:0] count;
  logic [24:0]            opnd;       // latched element
  logic                   last_pend;
  logic [24:0]            sum_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   rdy_reg;

  // aligned operands: a carries the larger exponent, b is shifted
  logic                   sign_a, sign_b;
  logic [18:0]            mag_a, mag_b;
  logic signed [9:0]      exp_r;
  logic                   res_sign;
  logic [19:0]            mag_r;

  assign xfer            = bus.value_valid & (state == IDLE);
  assign bus.value_ready = ready;
  assign bus.sum         = sum_reg;
  assign bus.sum_count   = count_reg;
  assign bus.sum_rdy     = rdy_reg;

  // alignment: pick the larger exponent, truncate the other magnitude
  logic [7:0]  acc_e, op_e, big_e, diff;
  logic [18:0] acc_m, op_m, big_m, small_m, shifted;
  logic        big_s, small_s;
  always_comb begin
    acc_e = acc[23:16];
    op_e  = opnd[23:16];
    acc_m = (acc_e == 8'd0) ? 19'd0 : {1'b1, acc[15:0], 2'b00};
    op_m  = (op_e == 8'd0) ? 19'd0 : {1'b1, opnd[15:0], 2'b00};
    if (acc_e >= op_e) begin
      big_e   = acc_e;
      diff    = acc_e - op_e;
      big_m   = acc_m;
      big_s   = acc[24];
      small_m = op_m;
      small_s = opnd[24];
    end else begin
      big_e   = op_e;
      diff    = op_e - acc_e;
      big_m   = op_m;
      big_s   = opnd[24];
      small_m = acc_m;
      small_s = acc[24];
    end
    shifted = (diff >= 8'd19) ? 19'd0 : (small_m >> diff);
  end

  // signed-magnitude add; exact cancellation yields +0
  logic        add_s;
  logic [19:0] add_m;
  always_comb begin
    add_s = sign_a;
    add_m = {1'b0, mag_a} + {1'b0, mag_b};
    if (sign_a != sign_b) begin
      if (mag_a > mag_b) begin
        add_m = {1'b0, mag_a - mag_b};
      end else if (mag_b > mag_a) begin
        add_m = {1'b0, mag_b - mag_a};
        add_s = sign_b;
      end else begin
        add_m = 20'd0;
        add_s = 1'b0;
      end
    end
  end

  // normalisation finishes on zero, carry, underflow or hidden bit in place
  logic norm_done;
  assign norm_done = (mag_r == 20'd0) || mag_r[19] || mag_r[18] || (exp_r <= 10'sd0);

  // round half up on guard bit 1, saturate to infinity, keep infinity sticky
  logic [17:0]       rnd;
  logic signed [9:0] rnd_e;
  logic [15:0]       rnd_f;
  logic [24:0]       rnd_val;
  always_comb begin
    rnd = {1'b0, mag_r[18:2]} + {17'd0, mag_r[1]};
    if (rnd[17]) begin
      rnd_e = exp_r + 10'sd1;
      rnd_f = 16'd0;
    end else begin
      rnd_e = exp_r;
      rnd_f = rnd[15:0];
    end
    if (acc[23:16] == 8'hFF)        rnd_val = acc;
    else if (rnd[17:16] == 2'b00)   rnd_val = 25'd0;
    else if (rnd_e >= 10'sd255)     rnd_val = {res_sign, 8'hFF, 16'h0000};
    else                            rnd_val = {res_sign, rnd_e[7:0], rnd_f};
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state and handshake
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (xfer) state_nxt = ALIGN;
      end
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath and result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc       <= 25'd0;
      count     <= '0;
      opnd      <= 25'd0;
      last_pend <= 1'b0;
      sum_reg   <= 25'd0;
      count_reg <= '0;
      rdy_reg   <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      mag_a     <= 19'd0;
      mag_b     <= 19'd0;
      exp_r     <= 10'sd0;
      res_sign  <= 1'b0;
      mag_r     <= 20'd0;
    end else begin
      rdy_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            opnd      <= bus.fp_value;
            last_pend <= bus.value_last;
            if (bus.acc_clear) begin
              acc   <= 25'd0;
              count <= COUNT_WIDTH'(1);
            end else begin
              count <= count + COUNT_WIDTH'(1);
            end
          end else if (bus.acc_clear) begin
            acc   <= 25'd0;
            count <= '0;
          end
        end
        ALIGN: begin
          sign_a <= big_s;
          mag_a  <= big_m;
          sign_b <= small_s;
          mag_b  <= shifted;
          exp_r  <= $signed({2'b00, big_e});
        end
        ADD: begin
          res_sign <= add_s;
          mag_r    <= add_m;
        end
        NORM: begin
          if (mag_r == 20'd0) begin
            res_sign <= 1'b0;
          end else if (mag_r[19]) begin
            mag_r <= mag_r >> 1;
            exp_r <= exp_r + 10'sd1;
          end else if (exp_r <= 10'sd0) begin
            mag_r    <= 20'd0;
            res_sign <= 1'b0;
          end else if (!mag_r[18]) begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - 10'sd1;
          end
        end
        ROUND: begin
          if (last_pend) begin
            sum_reg   <= rnd_val;
            count_reg <= count;
            rdy_reg   <= 1'b1;
            acc       <= 25'd0;
            count     <= '0;
          end else begin
            acc <= rnd_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator_bfloat16.sv
// Bench for the bfloat16 accumulator: directed vector table, timing and
// control sequences, then random sums against an arithmetic reference.
module tb_fp_accumulator_bfloat16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fp_accumulator_bfloat16_if #(.COUNT_WIDTH(CW)) bus ();
  fp_accumulator_bfloat16 #(.COUNT_WIDTH(CW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int total = 0;
  int bad = 0;

  logic [24:0]   sq[$];
  logic [CW-1:0] cq[$];

  // capture every emitted sum
  always @(negedge clk) begin
    if (bus.sum_rdy === 1'b1) begin
      sq.push_back(bus.sum);
      cq.push_back(bus.sum_count);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (bus.value_ready !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [24:0] v, input logic last, input logic clr);
    wait_idle();
    bus.value_valid = 1'b1;
    bus.fp_value    = v;
    bus.value_last  = last;
    bus.acc_clear   = clr;
    @(negedge clk);
    bus.value_valid = 1'b0;
    bus.value_last  = 1'b0;
    bus.acc_clear   = 1'b0;
  endtask

  task automatic get_sum(output logic [24:0] s, output logic [CW-1:0] c);
    int g = 0;
    while (sq.size() == 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sq.size() == 0) begin
      check("sum_timeout", 64'd0, 64'd1);
      s = 'x;
      c = 'x;
    end else begin
      s = sq.pop_front();
      c = cq.pop_front();
    end
  endtask

  // drive one element from IDLE and report the cycles at which ready
  // returns and sum_rdy pulses (transfer cycle is 0)
  task automatic timed(input logic [24:0] v, input logic last, output int rdy_at, output int pulse_at);
    @(negedge clk);
    bus.value_valid = 1'b1;
    bus.fp_value    = v;
    bus.value_last  = last;
    rdy_at   = -1;
    pulse_at = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.value_valid = 1'b0;
        bus.value_last  = 1'b0;
      end
      if (rdy_at < 0 && bus.value_ready === 1'b1) rdy_at = n;
      if (pulse_at < 0 && bus.sum_rdy === 1'b1) pulse_at = n;
    end
  endtask

  // reference: exact integer arithmetic on scaled magnitudes
  function automatic logic [24:0] model_add(input logic [24:0] a, input logic [24:0] x);
    int     ea, ex, e, d;
    longint ma, mx, s, m;
    logic   sg;
    if (a[23:16] == 8'hFF) return a;
    ea = int'(a[23:16]);
    ex = int'(x[23:16]);
    ma = (ea == 0) ? 0 : (longint'(65536) + longint'(a[15:0])) * 4;
    mx = (ex == 0) ? 0 : (longint'(65536) + longint'(x[15:0])) * 4;
    if (ea >= ex) begin
      e = ea; d = ea - ex;
      mx = (d >= 19) ? 0 : (mx >> d);
    end else begin
      e = ex; d = ex - ea;
      ma = (d >= 19) ? 0 : (ma >> d);
    end
    s = (a[24] ? -ma : ma) + (x[24] ? -mx : mx);
    if (s == 0) return 25'd0;
    sg = (s < 0);
    if (sg) s = -s;
    if (s >= 524288) begin
      s = s >> 1;
      e++;
    end
    while (s < 262144) begin
      s = s << 1;
      e--;
    end
    if (e <= 0) return 25'd0;
    m = (s >> 2) + ((s >> 1) & 1);
    if (m >= 131072) begin
      e++;
      m = 65536;
    end
    if (e >= 255) return {sg, 8'hFF, 16'h0000};
    return {sg, e[7:0], m[15:0]};
  endfunction

  function automatic logic [24:0] rand_val();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 15);
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'($urandom_range(248, 254));
    else             e = 8'($urandom_range(112, 140));
    return {1'($urandom_range(0, 1)), e, 16'($urandom)};
  endfunction

  typedef struct {
    string       name;
    int          n;
    logic [24:0] v0, v1, v2;
    logic [24:0] want_sum;
    int          want_cnt;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [24:0]   s, v, macc;
    logic [CW-1:0] c;
    int            ra, pa, mcnt, nel;
    logic          clr;

    vecs[0]  = '{"single",        1, 25'h07F0000, 25'h0,       25'h0,       25'h07F0000, 1};
    vecs[1]  = '{"one_plus_one",  2, 25'h07F0000, 25'h07F0000, 25'h0,       25'h0800000, 2};
    vecs[2]  = '{"one_plus_half", 2, 25'h07F0000, 25'h07E0000, 25'h0,       25'h07F8000, 2};
    vecs[3]  = '{"cancel",        2, 25'h07F0000, 25'h17F0000, 25'h0,       25'h0000000, 2};
    vecs[4]  = '{"one5_min_one",  2, 25'h07F8000, 25'h17F0000, 25'h0,       25'h07E0000, 2};
    vecs[5]  = '{"lsb_round_up",  2, 25'h07F0000, 25'h06E0000, 25'h0,       25'h07F0001, 2};
    vecs[6]  = '{"guard0_only",   2, 25'h07F0000, 25'h06D0000, 25'h0,       25'h07F0000, 2};
    vecs[7]  = '{"far_small",     2, 25'h07F0000, 25'h06B0000, 25'h0,       25'h07F0000, 2};
    vecs[8]  = '{"overflow",      2, 25'h0FEFFFF, 25'h0FEFFFF, 25'h0,       25'h0FF0000, 2};
    vecs[9]  = '{"inf_sticky",    3, 25'h0FEFFFF, 25'h0FEFFFF, 25'h07F0000, 25'h0FF0000, 3};
    vecs[10] = '{"inf_minus_inf", 3, 25'h0FEFFFF, 25'h0FEFFFF, 25'h1FF0000, 25'h0FF0000, 3};
    vecs[11] = '{"neg_result",    2, 25'h17F0000, 25'h07E0000, 25'h0,       25'h17E0000, 2};
    vecs[12] = '{"underflow",     2, 25'h0010000, 25'h1018000, 25'h0,       25'h0000000, 2};
    vecs[13] = '{"zero_first",    2, 25'h0000000, 25'h07F0000, 25'h0,       25'h07F0000, 2};
    vecs[14] = '{"round_carry",   2, 25'h07FFFFF, 25'h06E0000, 25'h0,       25'h0800000, 2};

    bus.value_valid = 1'b0;
    bus.value_last  = 1'b0;
    bus.fp_value    = 25'd0;
    bus.acc_clear   = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.value_ready), 64'd1);
    check("rst_sum_rdy", 64'(bus.sum_rdy), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_count", 64'(bus.sum_count), 64'd0);
    rstn = 1'b1;

    // latency of a single term
    wait_idle();
    timed(25'h07F0000, 1'b1, ra, pa);
    check("single_ready_cycle", 64'(ra), 64'd5);
    check("single_pulse_cycle", 64'(pa), 64'd5);
    get_sum(s, c);
    check("single_sum", 64'(s), 64'h07F0000);
    check("single_count", 64'(c), 64'd1);

    // one left shift in NORM costs one cycle
    send(25'h07F8000, 1'b0, 1'b0);
    wait_idle();
    timed(25'h17F0000, 1'b1, ra, pa);
    check("shift_ready_cycle", 64'(ra), 64'd6);
    check("shift_pulse_cycle", 64'(pa), 64'd6);
    get_sum(s, c);
    check("shift_sum", 64'(s), 64'h07E0000);
    check("shift_count", 64'(c), 64'd2);

    // directed vector table
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        v = (k == 0) ? vecs[i].v0 : (k == 1) ? vecs[i].v1 : vecs[i].v2;
        send(v, k == vecs[i].n - 1, 1'b0);
      end
      get_sum(s, c);
      check({vecs[i].name, "_sum"}, 64'(s), 64'(vecs[i].want_sum));
      check({vecs[i].name, "_count"}, 64'(c), 64'(vecs[i].want_cnt));
      repeat (3) @(negedge clk);
      check({vecs[i].name, "_hold"}, 64'(bus.sum), 64'(vecs[i].want_sum));
    end

    // valid held high: transfers at cycles 0, 5, 10 only; junk driven
    // while busy must be ignored
    wait_idle();
    for (int n = 0; n <= 10; n++) begin
      bus.value_valid = 1'b1;
      if (n % 5 == 0) begin
        bus.fp_value   = 25'h07F0000;
        bus.value_last = 1'b0;
      end else begin
        bus.fp_value   = 25'h1FE1234;
        bus.value_last = 1'b1;
      end
      @(negedge clk);
    end
    bus.value_valid = 1'b0;
    bus.value_last  = 1'b0;
    send(25'h07F0000, 1'b1, 1'b0);
    get_sum(s, c);
    check("hold_valid_sum", 64'(s), 64'h0810000);
    check("hold_valid_count", 64'(c), 64'd4);

    // clear in IDLE without a transfer
    send(25'h0800000, 1'b0, 1'b0);
    send(25'h0810000, 1'b0, 1'b0);
    wait_idle();
    bus.acc_clear = 1'b1;
    @(negedge clk);
    bus.acc_clear = 1'b0;
    send(25'h07F0000, 1'b0, 1'b0);
    send(25'h07F0000, 1'b1, 1'b0);
    get_sum(s, c);
    check("clear_idle_sum", 64'(s), 64'h0800000);
    check("clear_idle_count", 64'(c), 64'd2);

    // clear together with a transfer
    send(25'h0810000, 1'b0, 1'b0);
    send(25'h07F0000, 1'b1, 1'b1);
    get_sum(s, c);
    check("clear_xfer_sum", 64'(s), 64'h07F0000);
    check("clear_xfer_count", 64'(c), 64'd1);

    // reset during a long NORM: no sum, reset values restored
    send(25'h07F0000, 1'b0, 1'b0);
    send(25'h17F0001, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.value_ready), 64'd1);
    check("midrst_sum_rdy", 64'(bus.sum_rdy), 64'd0);
    check("midrst_sum", 64'(bus.sum), 64'd0);
    check("midrst_count", 64'(bus.sum_count), 64'd0);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_pulse", 64'(sq.size()), 64'd0);
    send(25'h07F0000, 1'b1, 1'b0);
    get_sum(s, c);
    check("after_rst_sum", 64'(s), 64'h07F0000);
    check("after_rst_count", 64'(c), 64'd1);

    // counter wrap: 2^CW + 1 elements
    for (int i = 0; i < (1 << CW); i++) send(25'h0000000, 1'b0, 1'b0);
    send(25'h0000000, 1'b1, 1'b0);
    get_sum(s, c);
    check("wrap_sum", 64'(s), 64'd0);
    check("wrap_count", 64'(c), 64'd1);

    // random sums against the reference model
    macc = 25'd0;
    mcnt = 0;
    for (int t = 0; t < 40; t++) begin
      nel = $urandom_range(1, 5);
      for (int k = 0; k < nel; k++) begin
        v   = rand_val();
        clr = ($urandom_range(0, 9) == 0);
        if (clr) begin
          macc = 25'd0;
          mcnt = 0;
        end
        macc = model_add(macc, v);
        mcnt++;
        send(v, k == nel - 1, clr);
      end
      get_sum(s, c);
      check("rand_sum", 64'(s), 64'(macc));
      check("rand_count", 64'(c), 64'(mcnt % (1 << CW)));
      macc = 25'd0;
      mcnt = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_accumulator_bfloat16.md
# fp_accumulator_bfloat16

Multi-cycle floating-point accumulator for the bfloat16 datapath. It sits directly downstream of the bfloat16 multiplier and consumes its 25-bit products: sign, 8-bit biased exponent and 16-bit fraction. It sums a sequence of products, one element at a time, and emits the rounded 25-bit sum when the element marked last has been absorbed. Typical use is a dot-product reduction.

## Interface
- COUNT_WIDTH, 16: width of the element counter reported with each sum.

- clk  in  1  clock; all state changes on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- value_valid  in  1  input element present.
- value_ready  out  1  block can accept an element this cycle.
- value_last  in  1  element is the final term of the current sum; sampled with the transfer.
- fp_value  in  25  element: [24] sign, [23:16] exponent with bias 127 (0 means zero), [15:0] fraction with hidden 1.
- acc_clear  in  1  synchronous clear; honoured only in IDLE.
- sum_rdy  out  1  one-cycle pulse; sum and sum_count are valid with it. There is no backpressure.
- sum  out  25  accumulated result, same format as fp_value.
- sum_count  out  COUNT_WIDTH  number of elements in sum, wrapping modulo 2^COUNT_WIDTH.

## Operation
- Reset values:
  - value_ready = 1, sum_rdy = 0, sum = 0, sum_count = 0.
  - Accumulator = +0, element counter = 0, state = IDLE.
- Internal magnitude format: 19 bits = {hidden, 16 fraction, 2 guard}. The magnitude is 0 when the exponent is 0. The exponent is tracked as a 10-bit signed value.
- IDLE state:
  - value_ready = 1.
  - A transfer occurs when value_valid and value_ready are both 1. The block latches fp_value and value_last, increments the counter, and goes to ALIGN.
  - acc_clear in IDLE without a transfer clears the accumulator and the counter.
  - acc_clear together with a transfer: the clear applies first and the element becomes the first term.
- ALIGN state (1 cycle):
  - The operand with the larger exponent sets the result exponent.
  - The other magnitude is shifted right by the exponent difference. Bits shifted below guard bit 0 are discarded (truncation).
  - If the difference is 19 or more, the smaller operand becomes 0.
- ADD state (1 cycle):
  - Equal signs: 20-bit sum of the magnitudes.
  - Unequal signs: larger minus smaller, and the result takes the sign of the larger. Equal magnitudes give +0.
- NORM state:
  - If bit 19 is set: shift right 1, exponent +1, one cycle.
  - Otherwise shift left 1 and decrement the exponent per cycle until bit 18 is set.
  - A zero magnitude exits immediately as +0.
  - If the exponent reaches 0 or below, the result flushes to +0.
- ROUND state (1 cycle):
  - Round half up on guard bit 1: mantissa17 = mag[18:2] + mag[1].
  - On carry out, exponent +1 and the mantissa is re-normalised to 1.0.
  - Exponent ≥ 255 gives infinity {sign, 8'hFF, 16'h0}.
  - Infinity is sticky: further additions leave the accumulator unchanged until it is cleared. Inf + (−inf) keeps the earlier sign.
  - The rounded value is written to the accumulator.
  - If last was latched: sum = accumulator value, sum_count = counter, sum_rdy pulses on the next cycle, and the accumulator and counter are cleared to 0.
  - The state then returns to IDLE.
- value_ready is 0 in every state except IDLE.

## Timing
- A transfer at cycle 0 is followed by ALIGN (1), ADD (2), NORM (3) and ROUND (4). value_ready is high again at cycle 5.
- Each left shift in NORM adds one cycle. A full cancellation to nonzero adds at most 18 cycles.
- The sum_rdy pulse lands in the cycle value_ready returns high (cycle 5 with no left shifts). A new element may transfer in that same cycle.
- sum and sum_count hold their values until the next sum_rdy.
- Reset asserted mid-operation: immediate return to the reset values. The partial sum and the pending last are discarded, and no sum_rdy is produced.
- Changes to value_last or fp_value while value_ready = 0 are ignored.

## Test plan
- Single term: 1.0 (25'h07F0000) with last → sum_rdy at cycle 5, sum = 25'h07F0000, sum_count = 1.
- Same-exponent add: 1.0 then 1.0 with last → sum = 25'h0800000 (2.0), sum_count = 2. Also 1.0 + 0.5 (25'h07E0000) → 25'h07F8000.
- Cancellation:
  - 1.0 + (−1.0) (25'h17F0000) → sum = 25'h0000000, with a positive zero sign.
  - 1.5 (25'h07F8000) + (−1.0) → 25'h07E0000, and value_ready is low for one extra NORM cycle.
- Rounding and alignment:
  - 1.0 + 2^-17 (25'h06E0000) → 25'h07F0001.
  - 1.0 + 2^-18 (25'h06D0000) → 25'h07F0000.
  - 1.0 + 2^-20 → 25'h07F0000.
- Overflow and stickiness: 25'h0FEFFFF + 25'h0FEFFFF → 25'h0FF0000; a further +1.0 with last → 25'h0FF0000.
- Control:
  - Hold value_valid high through the busy states: exactly one transfer per IDLE visit.
  - acc_clear mid-sum: the next sum includes only the later elements.
  - rstn pulsed low during NORM: value_ready = 1 and no sum_rdy.
  - After 2^COUNT_WIDTH+1 elements, sum_count wraps to 1.
